// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch slice.
//   DEF_ADDR_W / DEF_INSTR_W / DEF_RESET_PC : default geometry and reset PC
//   fetch_state_t                           : sequencer state encoding
//   fetch_entry_t                           : one prefetch buffer entry {pc, instr}
package fetch_sequencer_pkg;

  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction memory address/data plus the
// valid/ready handshake towards decode.
//   master : the fetch sequencer (drives imem_addr and the out_* payload)
//   slave  : memory + decode side (drives imem_rdata and out_ready)
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
);

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_sequencer_fifo.sv
// fetch_fifo: parameterised synchronous FIFO holding prefetched entries.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (accepted when not full, or full with a pop)
//   pop      : drop the head entry (ignored when empty)
//   flush    : discard all entries, pointers back to zero
//   wdata    : entry to write
//   head     : head entry, all-zero while empty
//   count    : number of stored entries
module fetch_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  T                           wdata,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                   mem [DEPTH];
  logic [PTR_W-1:0]   rd_q;
  logic [PTR_W-1:0]   wr_q;
  logic [CNT_W-1:0]   count_q;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: nothing is visible while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_q] <= wdata;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_q];
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter sequencer plus prefetch buffer.
// Drives a combinational instruction memory and presents fetched
// instructions to decode over valid/ready.
//   clk, rst       : clock, synchronous active-high reset
//   start          : pulse, IDLE -> RUN (fetching resumes from current PC)
//   stop           : pulse, RUN -> DRAIN (decode empties the buffer)
//   bus            : imem_addr/imem_rdata and out_valid/out_ready/out_instr/out_pc
//   redirect_valid : taken branch/jump; flush buffer and load redirect_pc
//   redirect_pc    : new program counter
//   busy           : sequencer is not IDLE
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned INSTR_W  = DEF_INSTR_W,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  fetch_sequencer_if.master bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  entry_t            wr_entry;
  entry_t            head;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));

  assign pop  = ~fifo_empty & bus.out_ready;
  assign push = (state_q == RUN) & ~redirect_valid & (~fifo_full | pop);

  assign wr_entry = '{pc: pc_q, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .head  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // PC wraps modulo 2^ADDR_W through natural overflow.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (push)       pc_d = pc_q + ADDR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // start wins over a coincident stop
        if (start) state_d = RUN;
      end
      RUN: begin
        if (stop) state_d = redirect_valid ? IDLE : DRAIN;
      end
      DRAIN: begin
        // An empty buffer cannot have a pop pending.
        if (redirect_valid || fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [9:0] redirect_pc = '0;
  logic       busy;

  int tests = 0;
  int fails = 0;

  fetch_entry_t exp_q[$];

  fetch_sequencer_if #(.ADDR_W(10), .INSTR_W(16)) bus ();

  fetch_sequencer #(
    .ADDR_W   (10),
    .INSTR_W  (16),
    .DEPTH    (2),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [15:0] word_of(int unsigned a);
    return 16'((a * 40503) ^ 32'h5A3C);
  endfunction

  assign bus.imem_rdata = word_of(32'(bus.imem_addr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(int unsigned pc);
    fetch_entry_t e;
    e.pc    = 10'(pc);
    e.instr = word_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b required 0", busy); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b required 0", bus.out_valid); end
    tests++; if (bus.imem_addr !== 10'd0) begin fails++; $display("FAIL reset_addr: got %0h required 0", bus.imem_addr); end
    tests++; if (bus.out_pc !== 10'd0) begin fails++; $display("FAIL reset_out_pc: got %0h required 0", bus.out_pc); end
    tests++; if (bus.out_instr !== 16'd0) begin fails++; $display("FAIL reset_out_instr: got %0h required 0", bus.out_instr); end
  endtask

  task automatic test_basic();
    fetch_entry_t e;
    do_reset();
    for (int unsigned p = 0; p < 6; p++) expect_pc(p);
    start = 1'b1; bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL start_lat_n1: got valid %0b required 0", bus.out_valid); end
    tick();
    for (int c = 0; c < 6; c++) begin
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_throughput: cycle %0d got valid %0b required 1", c, bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL basic_extra: got pc %0h required no delivery", bus.out_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
            fails++; $display("FAIL basic_data: got pc %0h instr %0h required pc %0h instr %0h", bus.out_pc, bus.out_instr, e.pc, e.instr);
          end
        end
      end
      tick();
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL basic_missing: got %0d undelivered required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    fetch_entry_t e;
    int got;
    do_reset();
    for (int unsigned p = 0; p < 4; p++) expect_pc(p);
    start = 1'b1; bus.out_ready = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    tests++; if (bus.imem_addr !== 10'd2) begin fails++; $display("FAIL bp_addr: got %0h required 2", bus.imem_addr); end
    tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 10'd0) begin fails++; $display("FAIL bp_head: got valid %0b pc %0h required 1 0", bus.out_valid, bus.out_pc); end
    tick();
    tests++; if (bus.imem_addr !== 10'd2) begin fails++; $display("FAIL bp_addr_hold: got %0h required 2", bus.imem_addr); end
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 4; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        tests++; got++;
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          fails++; $display("FAIL bp_data: got pc %0h instr %0h required pc %0h instr %0h", bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    tests++; if (got != 4) begin fails++; $display("FAIL bp_count: got %0d deliveries required 4", got); end
  endtask

  task automatic test_redirect();
    fetch_entry_t e;
    do_reset();
    for (int unsigned p = 0; p < 5; p++) expect_pc(p);
    start = 1'b1; bus.out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b1;
    // four pops of 0..3 leave pc 4 at the head and pc 5 behind it
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        redirect_valid = 1'b1; redirect_pc = 10'h3F0;
      end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          fails++; $display("FAIL redir_pre: got pc %0h instr %0h required pc %0h instr %0h", bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end else begin
        tests++; fails++; $display("FAIL redir_pre_valid: cycle %0d got valid 0 required 1", c);
      end
      tick();
    end
    redirect_valid = 1'b0;
    expect_pc(10'h3F0); expect_pc(10'h3F1);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL redir_flush: got valid %0b required 0", bus.out_valid); end
    tests++; if (bus.imem_addr !== 10'h3F0) begin fails++; $display("FAIL redir_addr: got %0h required 3f0", bus.imem_addr); end
    tick();
    for (int c = 0; c < 2; c++) begin
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL redir_valid: cycle %0d got %0b required 1", c, bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          fails++; $display("FAIL redir_data: got pc %0h instr %0h required pc %0h instr %0h", bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL redir_missing: got %0d undelivered required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    fetch_entry_t e;
    do_reset();
    expect_pc(1022); expect_pc(1023); expect_pc(0); expect_pc(1);
    start = 1'b1; bus.out_ready = 1'b1;
    tick();
    start = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd1022;
    tick();
    redirect_valid = 1'b0;
    tests++; if (bus.imem_addr !== 10'd1022) begin fails++; $display("FAIL wrap_addr: got %0d required 1022", bus.imem_addr); end
    tick();
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (!(bus.out_valid === 1'b1 && exp_q.size() != 0)) begin
        fails++; $display("FAIL wrap_valid: cycle %0d got valid %0b required 1", c, bus.out_valid);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          fails++; $display("FAIL wrap_data: got pc %0d instr %0h required pc %0d instr %0h", bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      tick();
    end
  endtask

  task automatic test_stop_drain();
    fetch_entry_t e;
    int after;
    do_reset();
    expect_pc(0); expect_pc(1); expect_pc(2);
    start = 1'b1; bus.out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1; bus.out_ready = 1'b1;
    if (bus.out_valid && bus.out_ready) begin
      tests++;
      e = exp_q.pop_front();
      if (bus.out_pc !== e.pc) begin fails++; $display("FAIL stop_first: got pc %0h required %0h", bus.out_pc, e.pc); end
    end
    tick();
    stop = 1'b0;
    after = 0;
    for (int c = 0; c < 8 && busy; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        after++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL drain_extra: got pc %0h required no delivery", bus.out_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
            fails++; $display("FAIL drain_data: got pc %0h instr %0h required pc %0h instr %0h", bus.out_pc, bus.out_instr, e.pc, e.instr);
          end
        end
      end
      tick();
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drain_idle: got busy %0b required 0", busy); end
    tests++; if (after != 2) begin fails++; $display("FAIL drain_count: got %0d outputs required 2", after); end
    tests++; if (bus.imem_addr !== 10'd3) begin fails++; $display("FAIL drain_pc: got %0h required 3", bus.imem_addr); end
    expect_pc(3); expect_pc(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      tests++;
      if (!(bus.out_valid === 1'b1 && exp_q.size() != 0)) begin
        fails++; $display("FAIL resume_valid: cycle %0d got valid %0b required 1", c, bus.out_valid);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          fails++; $display("FAIL resume_data: got pc %0h instr %0h required pc %0h instr %0h", bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; bus.out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h100;
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %0b required 0", bus.out_valid); end
    tests++; if (bus.imem_addr !== 10'd0) begin fails++; $display("FAIL rstmid_addr: got %0h required 0", bus.imem_addr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b required 0", busy); end
    tick();
    tick();
    tests++; if (bus.imem_addr !== 10'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got addr %0h valid %0b required 0 0", bus.imem_addr, bus.out_valid); end
  endtask

  task automatic test_redirect_stop();
    do_reset();
    start = 1'b1; bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h155;
    tick();
    stop = 1'b0; redirect_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rs_busy: got %0b required 0", busy); end
    tests++; if (bus.imem_addr !== 10'h155 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rs_state: got addr %0h valid %0b required 155 0", bus.imem_addr, bus.out_valid); end
    tick();
    tests++; if (bus.imem_addr !== 10'h155) begin fails++; $display("FAIL rs_hold: got %0h required 155", bus.imem_addr); end
    start = 1'b1; stop = 1'b1; bus.out_ready = 1'b0;
    tick();
    start = 1'b0; stop = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL startstop_busy: got %0b required 1", busy); end
    tick();
    tick();
    tests++; if (bus.imem_addr !== 10'h157) begin fails++; $display("FAIL startstop_run: got addr %0h required 157", bus.imem_addr); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++; if (busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_pc !== 10'h155) begin fails++; $display("FAIL drain_hold: got busy %0b valid %0b pc %0h required 1 1 155", busy, bus.out_valid, bus.out_pc); end
    redirect_valid = 1'b1; redirect_pc = 10'h200;
    tick();
    redirect_valid = 1'b0;
    tests++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 10'h200) begin fails++; $display("FAIL drain_redirect: got busy %0b valid %0b addr %0h required 0 0 200", busy, bus.out_valid, bus.imem_addr); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_stop_drain();
    test_reset_mid();
    test_redirect_stop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within 200000 time units");
    $fatal(1);
  end

endmodule
